microseq_next_state: RTL
========================

Name: microseq_next_state

Overview:
- Microprogram sequencer for the control unit. Holds the current microstore state and picks the next one each clock.
- Next-state sources:
  - decoded state number from the instruction encoder (8-bit, 0 = no match / reset);
  - incrementer;
  - jump target from the current microinstruction;
  - one-level return register.
- Sits directly downstream of the encoder. Its output addresses the control store ROM.
- Also supervises memory waits: a MOC timeout counter that aborts to a fault state.

Parameters:
W, 8, state/address width (matches encoder output width)
FETCH_STATE, 1, first fetch microstate, target of NS=111
UNDEF_STATE, 254, target when decode yields 0 (unrecognised instruction)
ABORT_STATE, 255, target on MOC timeout
TIMEOUT, 16, max consecutive wait cycles on MOC before abort (>=2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
enc_state  in  W  decoded state from instruction encoder
cr_addr  in  W  jump/call target field of current microinstruction
ns  in  3  next-state select field of current microinstruction
cond_sel  in  2  condition source: 00 moc, 01 cond_pass, 10 const 1, 11 const 0
inv  in  1  invert selected condition
moc  in  1  memory operation complete
cond_pass  in  1  ARM condition-code test result for the current instruction
state  out  W  current microstate (control store address)
undef  out  1  one-cycle pulse: decode produced no match
mem_abort  out  1  one-cycle pulse: MOC timeout taken

Behaviour:
- Reset (synchronous, highest priority):
  - state=0, ret=0, wait_cnt=0, undef=0, mem_abort=0.
  - Reset held: state stays 0.
  - Reset mid-wait or mid-call discards ret and wait_cnt.
- cond = mux(cond_sel) XOR inv. This is combinational; it is evaluated from the inputs present before the clock edge.
- Increment: inc = state+1 mod 2^W, so 255 wraps to 0.
- Next state by ns, registered on each rising edge:
  - 000 DECODE: state<=enc_state. If enc_state==0: state<=UNDEF_STATE and undef=1 for one cycle.
  - 001 INC: state<=inc.
  - 010 JUMP: state<=cr_addr.
  - 011 CJUMP: cond ? cr_addr : inc.
  - 100 WAIT: cond ? inc : state (hold).
  - 101 CALL: ret<=inc; state<=cr_addr. A nested CALL overwrites ret; there is no stack.
  - 110 RETURN: state<=ret. ret is unchanged.
  - 111 RESTART: state<=FETCH_STATE.
- MOC timeout (counter wait_cnt, width clog2(TIMEOUT)+1):
  - Active only when ns=100 and cond_sel=00.
  - Each cycle with cond=0: wait_cnt++.
  - When cond=0 and wait_cnt==TIMEOUT-1: state<=ABORT_STATE, mem_abort=1 for one cycle, wait_cnt<=0. The hold is thus limited to TIMEOUT cycles.
  - cond=1, or any cycle not a MOC wait: wait_cnt<=0.
  - moc arriving in the same cycle the count hits the limit: the completion wins, so state<=inc and there is no abort.
- WAIT with cond_sel=01/10/11 never times out. A WAIT with cond_sel=11 and inv=0 is an intentional halt.
- undef and mem_abort are registered and cleared the following cycle unless re-triggered.
- Latency: one clock from inputs to state. There are no combinational paths from inputs to outputs.
- ns is X-free by contract. Any value outside the table is impossible with a 3-bit field.

Test Plan:
- Reset then fetch: assert reset 2 cycles with ns=001 → state=0, flags 0. Release, ns=111 → state=1. Then ns=001 → state=2.
- Decode: ns=000, enc_state=57 → state=57 next cycle. enc_state=0 → state=254, undef=1 for exactly one cycle.
- Conditional jump: state=10, ns=011, cond_sel=01, cr_addr=40.
  - cond_pass=1 → state=40.
  - From state=10 with cond_pass=0 → state=11.
  - Repeat with inv=1 → results swap.
- MOC wait:
  - State=20, ns=100, cond_sel=00, moc low 3 cycles then high → state holds at 20 for 3 cycles, then 21, wait_cnt=0.
  - Hold moc low with TIMEOUT=16 → state=255 after 16th low cycle, mem_abort pulse.
  - moc rising on the 16th cycle → state=21, no abort.
- Call/return plus wrap:
  - State=30, ns=101, cr_addr=100 → state=100, ret=31. Then ns=110 → state=31.
  - State=255, ns=001 → state=0.
- Reset mid-operation: during the MOC wait at count 10, assert reset → state=0, wait_cnt=0. A later wait needs the full 16 cycles to abort.

Source files
------------

// File: rtl/microseq_next_state.sv
// -----------------------------------------------------------------------------
// microseq_next_state
//
// Microprogram sequencer for the control unit. Holds the current microstore
// state (the control store ROM address) and chooses the next state on every
// rising clock edge. It also supervises memory waits: a MOC wait that runs for
// TIMEOUT consecutive unsatisfied cycles aborts to ABORT_STATE.
//
// Next-state sources: the instruction encoder's decoded state, the
// incrementer, the microinstruction jump/call target, and a one-level return
// register.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset (highest priority)
//   i_enc_state  decoded state from the instruction encoder (0 = no match)
//   i_cr_addr    jump/call target field of the current microinstruction
//   i_ns         next-state select field of the current microinstruction
//   i_cond_sel   condition source: 00 moc, 01 cond_pass, 10 const 1, 11 const 0
//   i_inv        invert the selected condition
//   i_moc        memory operation complete
//   i_cond_pass  condition-code test result for the current instruction
//   o_state      current microstate (registered)
//   o_undef      one-cycle pulse: decode produced no match (registered)
//   o_mem_abort  one-cycle pulse: MOC timeout taken (registered)
// -----------------------------------------------------------------------------
module microseq_next_state #(
  parameter int unsigned W           = 8,
  parameter int unsigned FETCH_STATE = 1,
  parameter int unsigned UNDEF_STATE = 254,
  parameter int unsigned ABORT_STATE = 255,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_enc_state,
  input  logic [W-1:0] i_cr_addr,
  input  logic [2:0]   i_ns,
  input  logic [1:0]   i_cond_sel,
  input  logic         i_inv,
  input  logic         i_moc,
  input  logic         i_cond_pass,
  output logic [W-1:0] o_state,
  output logic         o_undef,
  output logic         o_mem_abort
);

  // Wide enough to hold TIMEOUT itself, even though the count stops at TIMEOUT-1.
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  localparam logic [W-1:0]    FetchAddr   = W'(FETCH_STATE);
  localparam logic [W-1:0]    UndefAddr   = W'(UNDEF_STATE);
  localparam logic [W-1:0]    AbortAddr   = W'(ABORT_STATE);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  // Next-state select encoding of the microinstruction NS field.
  typedef enum logic [2:0] {
    NsDecode  = 3'b000,
    NsInc     = 3'b001,
    NsJump    = 3'b010,
    NsCjump   = 3'b011,
    NsWait    = 3'b100,
    NsCall    = 3'b101,
    NsReturn  = 3'b110,
    NsRestart = 3'b111
  } ns_e;

  // Condition source select.
  typedef enum logic [1:0] {
    CondMoc   = 2'b00,
    CondPass  = 2'b01,
    CondOne   = 2'b10,
    CondZero  = 2'b11
  } cond_sel_e;

  // Registered state.
  logic [W-1:0]    r_state;
  logic [W-1:0]    r_ret;
  logic [CntW-1:0] r_wait_cnt;
  logic            r_undef;
  logic            r_mem_abort;

  // Next-state values.
  logic [W-1:0]    w_state_d;
  logic [W-1:0]    w_ret_d;
  logic [CntW-1:0] w_wait_cnt_d;
  logic            w_undef_d;
  logic            w_mem_abort_d;

  // Decoded controls.
  ns_e             w_ns;
  cond_sel_e       w_cond_sel;
  logic            w_cond_raw;
  logic            w_cond;
  logic [W-1:0]    w_inc;
  logic            w_moc_wait;
  logic            w_limit;

  assign w_ns       = ns_e'(i_ns);
  assign w_cond_sel = cond_sel_e'(i_cond_sel);

  // Condition mux; evaluated from the inputs present before the clock edge.
  always_comb begin
    w_cond_raw = 1'b0;
    unique case (w_cond_sel)
      CondMoc:  w_cond_raw = i_moc;
      CondPass: w_cond_raw = i_cond_pass;
      CondOne:  w_cond_raw = 1'b1;
      CondZero: w_cond_raw = 1'b0;
    endcase
  end

  assign w_cond = w_cond_raw ^ i_inv;

  // Modulo-2^W increment: the top state wraps to 0.
  assign w_inc = r_state + W'(1);

  // Only a WAIT on MOC is supervised; other WAIT sources may hold forever
  // (cond_sel=11 with inv=0 is a deliberate halt).
  assign w_moc_wait = (w_ns == NsWait) && (w_cond_sel == CondMoc);

  // Last permitted hold cycle. Only consulted when the condition is false, so a
  // completion arriving on this very cycle wins over the abort.
  assign w_limit = (r_wait_cnt == TimeoutLast);

  always_comb begin
    w_state_d     = r_state;
    w_ret_d       = r_ret;
    w_wait_cnt_d  = '0;
    w_undef_d     = 1'b0;
    w_mem_abort_d = 1'b0;

    unique case (w_ns)
      NsDecode: begin
        if (i_enc_state == '0) begin
          w_state_d = UndefAddr;
          w_undef_d = 1'b1;
        end else begin
          w_state_d = i_enc_state;
        end
      end

      NsInc: w_state_d = w_inc;

      NsJump: w_state_d = i_cr_addr;

      NsCjump: w_state_d = w_cond ? i_cr_addr : w_inc;

      NsWait: begin
        if (w_cond) begin
          w_state_d = w_inc;
        end else if (w_moc_wait) begin
          if (w_limit) begin
            w_state_d     = AbortAddr;
            w_mem_abort_d = 1'b1;
          end else begin
            w_wait_cnt_d = r_wait_cnt + CntW'(1);
          end
        end
      end

      // Single-level linkage: a nested call simply overwrites the return address.
      NsCall: begin
        w_ret_d   = w_inc;
        w_state_d = i_cr_addr;
      end

      NsReturn: w_state_d = r_ret;

      NsRestart: w_state_d = FetchAddr;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= '0;
      r_ret       <= '0;
      r_wait_cnt  <= '0;
      r_undef     <= 1'b0;
      r_mem_abort <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ret       <= w_ret_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_undef     <= w_undef_d;
      r_mem_abort <= w_mem_abort_d;
    end
  end

  assign o_state     = r_state;
  assign o_undef     = r_undef;
  assign o_mem_abort = r_mem_abort;

endmodule
